// File: rtl/collatz_sweep_ctrl_if.sv
// Engine-side bus of the Collatz sweep controller: start/seed out, done/steps back.
interface collatz_sweep_ctrl_if #(
  parameter int SEED_W = 16,
  parameter int STEP_W = 12
) ();
  // Handshake: eng_st is a one-cycle start pulse with eng_co valid and held
  // until the result returns; eng_done is a one-cycle pulse qualifying eng_steps.
  // There is no back-pressure, and the controller ignores eng_done unless it is waiting.
  logic              eng_st;
  logic [SEED_W-1:0] eng_co;
  logic              eng_done;
  logic [STEP_W-1:0] eng_steps;

  modport master (
    output eng_st,
    output eng_co,
    input  eng_done,
    input  eng_steps
  );

  modport slave (
    input  eng_st,
    input  eng_co,
    output eng_done,
    output eng_steps
  );
endinterface

// File: rtl/collatz_sweep_ctrl.sv
// Sweeps seeds lo..hi through one Collatz engine and keeps the seed with the most steps.
// All outputs are registered; o_state exposes the FSM for observation.
module collatz_sweep_ctrl #(
  parameter int SEED_W  = 16,
  parameter int STEP_W  = 12,
  parameter int TIMEOUT = 4095
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_go,
  input  logic              i_abort,
  input  logic [SEED_W-1:0] i_lo,
  input  logic [SEED_W-1:0] i_hi,
  collatz_sweep_ctrl_if.master eng,
  output logic              o_busy,
  output logic              o_done,
  output logic [SEED_W-1:0] o_best_seed,
  output logic [STEP_W-1:0] o_best_steps,
  output logic [SEED_W:0]   o_count,
  output logic              o_timeout_err,
  output logic [2:0]        o_state
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_UPDATE = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_eng_st;
  logic [SEED_W-1:0] r_eng_co;
  logic [SEED_W-1:0] r_hi;
  logic [TMR_W-1:0]  r_timer;
  logic [STEP_W-1:0] r_steps;
  logic              r_valid;
  logic [SEED_W-1:0] r_best_seed;
  logic [STEP_W-1:0] r_best_steps;
  logic [SEED_W:0]   r_count;
  logic              r_timeout_err;
  logic              r_done;
  logic              r_busy;

  state_t            w_next_state;
  logic              w_accept;
  logic              w_result;
  logic              w_timeout;
  logic              w_update;
  logic [SEED_W-1:0] w_issue_seed;

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_result     = 1'b0;
    w_timeout    = 1'b0;
    w_update     = 1'b0;
    w_issue_seed = (r_state == S_IDLE) ? i_lo : r_eng_co + 1'b1;
    case (r_state)
      S_IDLE: begin
        if (i_go) begin
          w_accept     = 1'b1;
          w_next_state = (i_lo <= i_hi) ? S_ISSUE : S_FINISH;
        end
      end
      S_ISSUE: begin
        w_next_state = i_abort ? S_FINISH : S_WAIT;
      end
      S_WAIT: begin
        // Abort outranks a result or timeout arriving in the same cycle.
        if (i_abort) begin
          w_next_state = S_FINISH;
        end else if (eng.eng_done) begin
          w_result     = 1'b1;
          w_next_state = S_UPDATE;
        end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
          w_timeout    = 1'b1;
          w_next_state = S_UPDATE;
        end
      end
      S_UPDATE: begin
        if (i_abort) begin
          w_next_state = S_FINISH;
        end else begin
          w_update = 1'b1;
          // Equality stop lets hi = all-ones terminate without wrapping the seed.
          w_next_state = (r_eng_co == r_hi) ? S_FINISH : S_ISSUE;
        end
      end
      S_FINISH: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_eng_st      <= 1'b0;
      r_eng_co      <= '0;
      r_hi          <= '0;
      r_timer       <= '0;
      r_steps       <= '0;
      r_valid       <= 1'b0;
      r_best_seed   <= '0;
      r_best_steps  <= '0;
      r_count       <= '0;
      r_timeout_err <= 1'b0;
      r_done        <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_eng_st <= (w_next_state == S_ISSUE);
      r_done   <= (w_next_state == S_FINISH);
      r_busy   <= (w_next_state != S_IDLE);

      if (w_next_state == S_ISSUE) begin
        r_eng_co <= w_issue_seed;
      end

      if (r_state == S_ISSUE) begin
        r_timer <= '0;
      end else if (r_state == S_WAIT) begin
        r_timer <= r_timer + 1'b1;
      end

      if (w_result) begin
        r_steps <= eng.eng_steps;
        r_valid <= 1'b1;
      end else if (w_timeout) begin
        r_valid <= 1'b0;
      end

      if (w_accept) begin
        r_hi          <= i_hi;
        r_best_seed   <= '0;
        r_best_steps  <= '0;
        r_count       <= '0;
        r_timeout_err <= 1'b0;
      end else begin
        if (w_timeout) begin
          r_timeout_err <= 1'b1;
        end
        if (w_update) begin
          r_count <= r_count + 1'b1;
          // Strict compare keeps the earlier seed on a tie.
          if (r_valid && (r_steps > r_best_steps)) begin
            r_best_seed  <= r_eng_co;
            r_best_steps <= r_steps;
          end
        end
      end
    end
  end

  assign eng.eng_st    = r_eng_st;
  assign eng.eng_co    = r_eng_co;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_best_seed   = r_best_seed;
  assign o_best_steps  = r_best_steps;
  assign o_count       = r_count;
  assign o_timeout_err = r_timeout_err;
  assign o_state       = r_state;

endmodule

// File: tb/tb_collatz_sweep_ctrl.sv
// Directed bench for collatz_sweep_ctrl with a behavioural Collatz engine model.
module tb_collatz_sweep_ctrl;

  localparam int SEED_W  = 16;
  localparam int STEP_W  = 12;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              go = 1'b0;
  logic              abort = 1'b0;
  logic [SEED_W-1:0] lo = '0;
  logic [SEED_W-1:0] hi = '0;
  logic              o_busy;
  logic              o_done;
  logic [SEED_W-1:0] o_best_seed;
  logic [STEP_W-1:0] o_best_steps;
  logic [SEED_W:0]   o_count;
  logic              o_timeout_err;
  logic [2:0]        o_state;

  int tests = 0;
  int fails = 0;

  collatz_sweep_ctrl_if #(.SEED_W(SEED_W), .STEP_W(STEP_W)) eng_if ();

  collatz_sweep_ctrl #(.SEED_W(SEED_W), .STEP_W(STEP_W), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_go          (go),
    .i_abort       (abort),
    .i_lo          (lo),
    .i_hi          (hi),
    .eng           (eng_if),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_best_seed   (o_best_seed),
    .o_best_steps  (o_best_steps),
    .o_count       (o_count),
    .o_timeout_err (o_timeout_err),
    .o_state       (o_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- engine model and monitor ----------------
  int                eng_lat = 5;
  logic              silent_en = 1'b0;
  logic [SEED_W-1:0] silent_seed = '0;
  int                rem = 0;
  logic [SEED_W-1:0] cap_seed = '0;
  int                st_cnt = 0;
  int                done_cnt = 0;
  int                done_cyc = 0;
  int                st_cyc_q[$];
  logic [SEED_W-1:0] st_seed_q[$];

  function automatic int csteps(input longint unsigned n);
    int s = 0;
    if (n == 0) return 0;
    while (n != 1 && s < 4095) begin
      if (n[0]) n = 3 * n + 1;
      else      n = n >> 1;
      s++;
    end
    return s;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      rem = 0;
      eng_if.eng_done = 1'b0;
      eng_if.eng_steps = '0;
    end else begin
      eng_if.eng_done = 1'b0;
      if (rem > 0) begin
        rem--;
        if (rem == 0 && !(silent_en && cap_seed == silent_seed)) begin
          eng_if.eng_done = 1'b1;
          eng_if.eng_steps = STEP_W'(csteps(longint'(cap_seed)));
        end
      end
      if (eng_if.eng_st) begin
        rem = eng_lat;
        cap_seed = eng_if.eng_co;
        st_cnt++;
        st_cyc_q.push_back(cyc);
        st_seed_q.push_back(eng_if.eng_co);
      end
    end
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_sweep(input logic [SEED_W-1:0] l, input logic [SEED_W-1:0] h,
                             output int go_cyc);
    @(negedge clk);
    go = 1'b1;
    lo = l;
    hi = h;
    go_cyc = cyc;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (o_done) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_until(input int target);
    int guard = 0;
    while (cyc < target && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    tests++;
    if (cyc !== target) begin
      fails++;
      $display("FAIL wait_until: cycle %0d, expected %0d", cyc, target);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    tests++; if (eng_if.eng_st !== 1'b0) begin fails++; $display("FAIL reset.eng_st: got %b expected 0", eng_if.eng_st); end
    tests++; if (eng_if.eng_co !== '0) begin fails++; $display("FAIL reset.eng_co: got %0d expected 0", eng_if.eng_co); end
    tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL reset.busy: got %b expected 0", o_busy); end
    tests++; if (o_done !== 1'b0) begin fails++; $display("FAIL reset.done: got %b expected 0", o_done); end
    tests++; if (o_best_seed !== '0) begin fails++; $display("FAIL reset.best_seed: got %0d expected 0", o_best_seed); end
    tests++; if (o_best_steps !== '0) begin fails++; $display("FAIL reset.best_steps: got %0d expected 0", o_best_steps); end
    tests++; if (o_count !== '0) begin fails++; $display("FAIL reset.count: got %0d expected 0", o_count); end
    tests++; if (o_timeout_err !== 1'b0) begin fails++; $display("FAIL reset.timeout_err: got %b expected 0", o_timeout_err); end
    tests++; if (o_state !== 3'd0) begin fails++; $display("FAIL reset.state: got %0d expected 0", o_state); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_sweep();
    int g, ok, st0, q0, dc0, first_st, last_seed;
    eng_lat = 5; silent_en = 1'b0;
    st0 = st_cnt; q0 = st_cyc_q.size(); dc0 = done_cnt;
    start_sweep(16'd1, 16'd10, g);
    tests++; if (o_busy !== 1'b1) begin fails++; $display("FAIL basic.busy_during: got %b expected 1", o_busy); end
    wait_done(200, ok);
    tests++; if (ok != 1) begin fails++; $display("FAIL basic.done_seen: got %0d expected 1", ok); end
    repeat (2) @(negedge clk);
    first_st  = (st_cyc_q.size() > q0) ? st_cyc_q[q0] : -1000;
    last_seed = (st_seed_q.size() > q0 + 9) ? int'(st_seed_q[q0 + 9]) : -1;
    tests++; if (o_best_seed !== 16'd9) begin fails++; $display("FAIL basic.best_seed: got %0d expected 9", o_best_seed); end
    tests++; if (o_best_steps !== 12'd19) begin fails++; $display("FAIL basic.best_steps: got %0d expected 19", o_best_steps); end
    tests++; if (o_count !== 17'd10) begin fails++; $display("FAIL basic.count: got %0d expected 10", o_count); end
    tests++; if (st_cnt - st0 != 10) begin fails++; $display("FAIL basic.st_pulses: got %0d expected 10", st_cnt - st0); end
    tests++; if (done_cnt - dc0 != 1) begin fails++; $display("FAIL basic.done_pulses: got %0d expected 1", done_cnt - dc0); end
    tests++; if (first_st - g != 1) begin fails++; $display("FAIL basic.go_to_issue: got %0d expected 1", first_st - g); end
    tests++; if (done_cyc - first_st != 70) begin fails++; $display("FAIL basic.sweep_cycles: got %0d expected 70", done_cyc - first_st); end
    tests++; if (last_seed != 10) begin fails++; $display("FAIL basic.last_seed: got %0d expected 10", last_seed); end
    tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL basic.busy_after: got %b expected 0", o_busy); end
    tests++; if (o_timeout_err !== 1'b0) begin fails++; $display("FAIL basic.timeout_err: got %b expected 0", o_timeout_err); end
  endtask

  task automatic test_tie();
    int g, ok;
    eng_lat = 3; silent_en = 1'b0;
    start_sweep(16'd12, 16'd13, g);
    wait_done(100, ok);
    tests++; if (ok != 1) begin fails++; $display("FAIL tie.done_seen: got %0d expected 1", ok); end
    repeat (2) @(negedge clk);
    tests++; if (o_best_seed !== 16'd12) begin fails++; $display("FAIL tie.best_seed: got %0d expected 12", o_best_seed); end
    tests++; if (o_best_steps !== 12'd9) begin fails++; $display("FAIL tie.best_steps: got %0d expected 9", o_best_steps); end
    tests++; if (o_count !== 17'd2) begin fails++; $display("FAIL tie.count: got %0d expected 2", o_count); end
  endtask

  task automatic test_empty_range();
    int g, st0;
    st0 = st_cnt;
    start_sweep(16'd5, 16'd4, g);
    tests++; if (o_done !== 1'b1 || cyc != g + 1) begin fails++; $display("FAIL empty.done_timing: done %b at cycle %0d expected 1 at %0d", o_done, cyc, g + 1); end
    repeat (3) @(negedge clk);
    tests++; if (st_cnt - st0 != 0) begin fails++; $display("FAIL empty.st_pulses: got %0d expected 0", st_cnt - st0); end
    tests++; if (o_count !== '0) begin fails++; $display("FAIL empty.count: got %0d expected 0", o_count); end
    tests++; if (o_best_seed !== '0) begin fails++; $display("FAIL empty.best_seed: got %0d expected 0", o_best_seed); end
    tests++; if (o_best_steps !== '0) begin fails++; $display("FAIL empty.best_steps: got %0d expected 0", o_best_steps); end
    tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL empty.busy: got %b expected 0", o_busy); end
  endtask

  task automatic test_timeout();
    int g, ok, q0, gap;
    eng_lat = 5; silent_en = 1'b1; silent_seed = 16'd7;
    q0 = st_cyc_q.size();
    start_sweep(16'd6, 16'd8, g);
    wait_done(150, ok);
    tests++; if (ok != 1) begin fails++; $display("FAIL timeout.done_seen: got %0d expected 1", ok); end
    repeat (2) @(negedge clk);
    silent_en = 1'b0;
    gap = (st_cyc_q.size() > q0 + 2) ? st_cyc_q[q0 + 2] - st_cyc_q[q0 + 1] : -1;
    tests++; if (o_timeout_err !== 1'b1) begin fails++; $display("FAIL timeout.err: got %b expected 1", o_timeout_err); end
    tests++; if (o_count !== 17'd3) begin fails++; $display("FAIL timeout.count: got %0d expected 3", o_count); end
    tests++; if (o_best_seed !== 16'd6) begin fails++; $display("FAIL timeout.best_seed: got %0d expected 6", o_best_seed); end
    tests++; if (o_best_steps !== 12'd8) begin fails++; $display("FAIL timeout.best_steps: got %0d expected 8", o_best_steps); end
    tests++; if (gap != 18) begin fails++; $display("FAIL timeout.issue_gap: got %0d expected 18", gap); end
  endtask

  task automatic test_wrap();
    int g, ok, st0, q0, s0, s1;
    eng_lat = 2;
    st0 = st_cnt; q0 = st_seed_q.size();
    start_sweep(16'hFFFE, 16'hFFFF, g);
    tests++; if (o_timeout_err !== 1'b0) begin fails++; $display("FAIL wrap.err_cleared: got %b expected 0", o_timeout_err); end
    wait_done(60, ok);
    tests++; if (ok != 1) begin fails++; $display("FAIL wrap.done_seen: got %0d expected 1", ok); end
    repeat (3) @(negedge clk);
    s0 = (st_seed_q.size() > q0)     ? int'(st_seed_q[q0])     : -1;
    s1 = (st_seed_q.size() > q0 + 1) ? int'(st_seed_q[q0 + 1]) : -1;
    tests++; if (st_cnt - st0 != 2) begin fails++; $display("FAIL wrap.st_pulses: got %0d expected 2", st_cnt - st0); end
    tests++; if (o_count !== 17'd2) begin fails++; $display("FAIL wrap.count: got %0d expected 2", o_count); end
    tests++; if (s0 != 65534 || s1 != 65535) begin fails++; $display("FAIL wrap.seeds: got %0d,%0d expected 65534,65535", s0, s1); end
    tests++; if (o_state !== 3'd0) begin fails++; $display("FAIL wrap.idle: got %0d expected 0", o_state); end
  endtask

  task automatic test_abort();
    int g, ab, st0, dc0, q0, s2;
    eng_lat = 5;
    st0 = st_cnt; dc0 = done_cnt; q0 = st_seed_q.size();
    start_sweep(16'd1, 16'd10, g);
    wait_until(g + 5);
    go = 1'b1; lo = 16'd100; hi = 16'd200;
    @(negedge clk);
    go = 1'b0;
    wait_until(g + 17);
    abort = 1'b1;
    ab = cyc;
    @(negedge clk);
    abort = 1'b0;
    tests++; if (o_done !== 1'b1 || cyc != ab + 1) begin fails++; $display("FAIL abort.done_timing: done %b at cycle %0d expected 1 at %0d", o_done, cyc, ab + 1); end
    repeat (25) @(negedge clk);
    s2 = (st_seed_q.size() > q0 + 2) ? int'(st_seed_q[q0 + 2]) : -1;
    tests++; if (o_count !== 17'd2) begin fails++; $display("FAIL abort.count: got %0d expected 2", o_count); end
    tests++; if (st_cnt - st0 != 3) begin fails++; $display("FAIL abort.st_pulses: got %0d expected 3", st_cnt - st0); end
    tests++; if (s2 != 3) begin fails++; $display("FAIL abort.third_seed: got %0d expected 3", s2); end
    tests++; if (done_cnt - dc0 != 1) begin fails++; $display("FAIL abort.done_pulses: got %0d expected 1", done_cnt - dc0); end
    tests++; if (o_best_seed !== 16'd2) begin fails++; $display("FAIL abort.best_seed: got %0d expected 2", o_best_seed); end
    tests++; if (o_best_steps !== 12'd1) begin fails++; $display("FAIL abort.best_steps: got %0d expected 1", o_best_steps); end
    tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL abort.busy: got %b expected 0", o_busy); end
  endtask

  task automatic test_reset_mid_sweep();
    int g, st0;
    eng_lat = 5;
    start_sweep(16'd1, 16'd10, g);
    wait_until(g + 10);
    tests++; if (o_busy !== 1'b1 || o_count !== 17'd1) begin fails++; $display("FAIL rstmid.pre: busy %b count %0d expected 1 1", o_busy, o_count); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (o_state !== 3'd0) begin fails++; $display("FAIL rstmid.state: got %0d expected 0", o_state); end
    tests++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin fails++; $display("FAIL rstmid.busy_done: got %b%b expected 00", o_busy, o_done); end
    tests++; if (o_count !== '0 || o_best_seed !== '0 || o_best_steps !== '0) begin fails++; $display("FAIL rstmid.results: count %0d seed %0d steps %0d expected 0", o_count, o_best_seed, o_best_steps); end
    tests++; if (eng_if.eng_st !== 1'b0 || eng_if.eng_co !== '0 || o_timeout_err !== 1'b0) begin fails++; $display("FAIL rstmid.eng: st %b co %0d err %b expected 0", eng_if.eng_st, eng_if.eng_co, o_timeout_err); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    st0 = st_cnt;
    repeat (10) @(negedge clk);
    tests++; if (o_state !== 3'd0 || st_cnt != st0 || o_count !== '0) begin fails++; $display("FAIL rstmid.stays_idle: state %0d new_st %0d count %0d expected 0", o_state, st_cnt - st0, o_count); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_sweep();
    test_tie();
    test_empty_range();
    test_timeout();
    test_wrap();
    test_abort();
    test_reset_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/collatz_sweep_ctrl.md
# collatz_sweep_ctrl

Range scheduler for the Collatz datapath. It takes a seed range [lo, hi] and issues one seed at a time to a single Collatz engine, which is the FSM-controlled shift/3k+1 unit with a step counter. It waits for each result and keeps the seed that needs the most steps. It sits between the host/test register interface and the engine, and is the only driver of the engine's start and seed inputs.

## Interface
- SEED_W, 16, seed width; matches the engine's `co` input.
- STEP_W, 12, width of the engine's step count.
- TIMEOUT, 4095, number of WAIT cycles allowed per seed before that seed is abandoned.

- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- go  in  1  start request; sampled only in IDLE.
- abort  in  1  stop the sweep early; ignored in IDLE.
- lo  in  SEED_W  first seed; sampled when go is accepted.
- hi  in  SEED_W  last seed, inclusive; sampled when go is accepted.
- eng_st  out  1  engine start; one-cycle pulse per seed.
- eng_co  out  SEED_W  seed presented to the engine; held stable from ISSUE through WAIT.
- eng_done  in  1  engine result valid; honoured only in WAIT.
- eng_steps  in  STEP_W  step count; valid in the cycle eng_done=1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a sweep ends (normal completion, empty range or abort).
- best_seed  out  SEED_W  seed with the largest step count so far.
- best_steps  out  STEP_W  step count of best_seed.
- count  out  SEED_W+1  number of seeds completed, including timed-out seeds.
- timeout_err  out  1  sticky; set when any seed times out; cleared on the next accepted go.

## Operation
- States: IDLE, ISSUE, WAIT, UPDATE, FINISH.
- IDLE, go=1:
  - Latch cur_seed←lo and hi_r←hi.
  - Clear best_seed, best_steps, count and timeout_err.
  - If lo≤hi, go to ISSUE; otherwise go to FINISH (empty range).
- ISSUE: eng_st=1 and eng_co=cur_seed. Clear the timer. Go to WAIT.
- WAIT: timer increments every cycle.
  - eng_done=1: latch eng_steps and go to UPDATE as a valid result.
  - Else, timer==TIMEOUT-1: set timeout_err and go to UPDATE as an invalid result.
- UPDATE:
  - Valid result with eng_steps > best_steps (strict): best_seed←cur_seed, best_steps←eng_steps. On a tie, the lower (earlier) seed is kept.
  - count←count+1.
  - If cur_seed==hi_r, go to FINISH; else cur_seed←cur_seed+1 and go to ISSUE.
  - The termination test is an equality compare, so hi=2^SEED_W−1 never wraps cur_seed.
- FINISH: done=1 for one cycle, then go to IDLE. Result outputs hold their values until the next accepted go.
- abort=1 in ISSUE, WAIT or UPDATE: go to FINISH next cycle.
  - The pending UPDATE is discarded and no further eng_st is issued.
  - Partial results are retained.
  - abort in FINISH is ignored.
- go while busy is ignored. eng_done outside WAIT is ignored.
- Seeds 0 and 1 are not special-cased; the engine's result is used as returned.
- Reset, at any time including mid-sweep: state=IDLE and every output is 0 (eng_st, eng_co, busy, done, best_seed, best_steps, count, timeout_err). Any in-flight engine result is dropped.

## Timing
- go sampled at edge N: state=ISSUE after N, and eng_st is high during cycle N+1.
- Empty range: FINISH after N, and done is high during cycle N+1.
- Per seed: 1 ISSUE cycle + L WAIT cycles + 1 UPDATE cycle, where L≥1 is the engine latency counted in WAIT cycles up to and including the eng_done cycle. The minimum is 3 cycles per seed.
- Timeout: UPDATE is entered after exactly TIMEOUT WAIT cycles.
- Last UPDATE → FINISH; done rises the following cycle, and busy falls with the exit from FINISH.
- abort sampled high at edge M: done is high in cycle M+1.
- All outputs are registered, Moore-style. eng_co changes only on entry to ISSUE.

## Test plan
- lo=1, hi=10, behavioural engine returning true Collatz step counts at L=5 → best_seed=9, best_steps=19, count=10, exactly 10 eng_st pulses, one done pulse 70 cycles after ISSUE entry.
- Tie: lo=12, hi=13 (both 9 steps) → best_seed=12, best_steps=9, count=2.
- Empty range: lo=5, hi=4 → no eng_st, done one cycle after go, count=0, best_* =0.
- TIMEOUT=16, engine silent for seed 7, range 6..8 → timeout_err=1, count=3, best_seed=6 (8 steps beats 3), seed 8 issued after 16 WAIT cycles.
- Wrap: lo=0xFFFE, hi=0xFFFF → exactly 2 seeds issued, count=2, sweep terminates.
- Abort in WAIT of the 3rd seed of 1..10 → done next cycle, count=2, no further eng_st, go ignored while busy. Then assert rst_n=0 during a new sweep → all outputs 0 immediately and the FSM is in IDLE.
